// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path: default sample/address
// widths and the ping-pong bank state encoding.
package fft_pkg;

    localparam int DEF_WIDTH  = 18;
    localparam int DEF_ADDR_W = 11;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/reorder_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// rd_data holds its value whenever rd_en is low, which the reader relies on to stall.
module reorder_bank_ram #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: scrambled-order FFT samples are written by index into
// one bank while the other drains in natural order through a 2-stage read pipeline.
//   state    | meaning
//   EMPTY    | free, may accept the next symbol
//   FILLING  | receiving samples of the current symbol
//   FULL     | symbol complete, waiting for its first read
//   DRAINING | being read out; freed on the do_last handshake
module fft_reorder_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  di_re,
    input  logic [WIDTH-1:0]  di_im,
    input  logic              di_en,
    input  logic [ADDR_W-1:0] di_addr,
    input  logic              di_last,
    output logic [WIDTH-1:0]  do_re,
    output logic [WIDTH-1:0]  do_im,
    output logic              do_valid,
    input  logic              do_ready,
    output logic              do_last,
    output logic              overflow,
    output logic              busy
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    bank_state_t       state [2];
    logic [LEN_W-1:0]  len [2];
    logic              order_ptr;
    logic              iss_active, iss_bank;
    logic [ADDR_W-1:0] iss_idx;
    logic              s1_valid, s1_bank, s1_last;
    logic              out_bank;
    logic [2*WIDTH-1:0] rdata [2];

    logic              wr_ok, wr_bank, wr_go;
    logic              start_bank, any_full, out_adv, can_issue;
    logic              cur_bank, cur_last, rd_go, free_go;
    logic [ADDR_W-1:0] cur_idx;
    logic [2*WIDTH-1:0] s1_data;

    always_comb begin
        wr_ok   = 1'b1;
        wr_bank = 1'b0;
        if (state[0] == FILLING)      wr_bank = 1'b0;
        else if (state[1] == FILLING) wr_bank = 1'b1;
        else if (state[0] == EMPTY)   wr_bank = 1'b0;
        else if (state[1] == EMPTY)   wr_bank = 1'b1;
        else                          wr_ok   = 1'b0;
    end

    assign wr_go      = di_en && wr_ok;
    assign start_bank = (state[order_ptr] == FULL) ? order_ptr : ~order_ptr;
    assign any_full   = (state[0] == FULL) || (state[1] == FULL);
    assign out_adv    = !do_valid || do_ready;
    assign can_issue  = !s1_valid || out_adv;
    // While a bank is mid-drain keep reading it; otherwise start the oldest FULL bank.
    assign cur_bank   = iss_active ? iss_bank : start_bank;
    assign cur_idx    = iss_active ? iss_idx : '0;
    assign cur_last   = ({1'b0, cur_idx} == len[cur_bank] - LEN_W'(1));
    assign rd_go      = can_issue && (iss_active || any_full);
    assign free_go    = do_valid && do_ready && do_last;
    assign s1_data    = rdata[s1_bank];
    assign busy       = (state[0] != EMPTY) || (state[1] != EMPTY) || s1_valid || do_valid;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank_ram #(.DATA_W(2*WIDTH), .ADDR_W(ADDR_W)) u_ram (
            .clk     (clk),
            .wr_en   (wr_go && (wr_bank == 1'(b))),
            .wr_addr (di_addr),
            .wr_data ({di_re, di_im}),
            .rd_en   (rd_go && (cur_bank == 1'(b))),
            .rd_addr (cur_idx),
            .rd_data (rdata[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state[0]   <= EMPTY;
            state[1]   <= EMPTY;
            len[0]     <= '0;
            len[1]     <= '0;
            order_ptr  <= 1'b0;
            iss_active <= 1'b0;
            iss_bank   <= 1'b0;
            iss_idx    <= '0;
            s1_valid   <= 1'b0;
            s1_bank    <= 1'b0;
            s1_last    <= 1'b0;
            out_bank   <= 1'b0;
            do_valid   <= 1'b0;
            do_re      <= '0;
            do_im      <= '0;
            do_last    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (di_en && !wr_ok) overflow <= 1'b1;

            if (wr_go) begin
                if (len[wr_bank] != LEN_MAX) len[wr_bank] <= len[wr_bank] + LEN_W'(1);
                state[wr_bank] <= di_last ? FULL : FILLING;
            end

            if (rd_go) begin
                if (!iss_active) state[cur_bank] <= DRAINING;
                iss_active <= !cur_last;
                iss_bank   <= cur_bank;
                iss_idx    <= cur_idx + ADDR_W'(1);
            end

            if (can_issue) begin
                s1_valid <= rd_go;
                s1_bank  <= cur_bank;
                s1_last  <= cur_last;
            end

            if (out_adv) begin
                do_valid <= s1_valid;
                if (s1_valid) begin
                    do_re    <= s1_data[2*WIDTH-1:WIDTH];
                    do_im    <= s1_data[WIDTH-1:0];
                    do_last  <= s1_last;
                    out_bank <= s1_bank;
                end
            end

            if (free_go) begin
                state[out_bank] <= EMPTY;
                len[out_bank]   <= '0;
                order_ptr       <= ~out_bank;
            end

            // A symbol completing while the other bank holds nothing becomes the oldest.
            if (wr_go && di_last &&
                (!(state[~wr_bank] inside {FULL, DRAINING}) || free_go))
                order_ptr <= wr_bank;
        end
    end

endmodule
